mips_multicycle_fsm: RTL and testbench

Owns the state register and sequencing of the multicycle MIPS core. It generalises the combinational per-state decoder with memory-bus wait handling, branch-delay-slot redirect, halt detection, sub-word byte-enable generation and fault trapping. It sits between the instruction register/ALU condition logic and the Avalon-style memory port, and feeds the datapath enables.

---
 rtl/mips_multicycle_fsm.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_mips_multicycle_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_fsm.sv
// mips_multicycle_fsm
// Control sequencer for the multicycle MIPS core. It owns the state register
// and drives the memory-bus strobes and the datapath enables. It also handles
// bus wait states, the branch-delay-slot redirect, halt detection, sub-word
// byte enables and misalignment traps.
//
// Optional build macro: MIPS_FSM_WATCHDOG_EN. When it is defined, a stalled
// bus access that lasts TIMEOUT_CYCLES cycles traps to FAULT.
//
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   opcode, func_code  IR[31:26], IR[5:0]
//   rt_code            IR[20:16], REGIMM selector
//   waitrequest        memory stall
//   addr_lo            effective address [1:0]
//   branch_taken       ALU condition result, with jump_target
//   jump_target        resolved branch/jump target
//   state              current state (FETCH=0 .. RESET=7)
//   active, fault      running / sticky trap flags
//   mem_read, mem_write, byteenable   bus strobes and lane enables
//   ir_write, pc_write, pc_redirect, reg_write   datapath enables
//   delay_slot         current instruction sits in a delay slot
//
// All outputs are registered except pc_write and pc_redirect. Those two are
// gated combinationally by waitrequest in FETCH.
// The instruction class, misalignment and byte lanes are sampled during
// EXECUTE. The IR fields and addr_lo must therefore be valid by then.

module mips_multicycle_fsm #(
  parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func_code,
  input  logic [4:0]  rt_code,
  input  logic        waitrequest,
  input  logic [1:0]  addr_lo,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  output logic [2:0]  state,
  output logic        active,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  byteenable,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_redirect,
  output logic        reg_write,
  output logic        delay_slot,
  output logic        fault
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;
  localparam logic [2:0] S_RESET = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [2:0] state_r, nxt_s, done_s;
  logic       load_s, store_s, wr_s, jump_s, cbranch_s, mis_s;
  logic [1:0] size_s;
  logic [3:0] be_s;
  logic       ld_r, st_r, wr_r, jmp_r, br_r, mis_r;
  logic [3:0] be_r;
  logic       ld_n_s, st_n_s, wr_n_s, mis_n_s;
  logic [3:0] be_n_s;
  logic       redirect_pending_r, halt_pending_r, delay_slot_r;
  logic       take_s, wd_expired_s;

  assign state       = state_r;
  assign delay_slot  = delay_slot_r;
  assign pc_write    = (state_r == S_FETCH) & ~waitrequest;
  assign pc_redirect = pc_write & redirect_pending_r;

  // Instruction class decode from the IR fields
  always_comb begin
    load_s    = 1'b0;
    store_s   = 1'b0;
    wr_s      = 1'b0;
    jump_s    = 1'b0;
    cbranch_s = 1'b0;
    size_s    = SZ_WORD;
    case (opcode)
      6'h00: begin
        case (func_code)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: wr_s = 1'b1;
          6'h08:        jump_s = 1'b1;
          6'h09: begin
            jump_s = 1'b1;
            wr_s   = 1'b1;
          end
          default:      wr_s = 1'b0;
        endcase
      end
      6'h01: begin
        case (rt_code)
          5'd0, 5'd1: cbranch_s = 1'b1;
          5'd16, 5'd17: begin
            cbranch_s = 1'b1;
            wr_s      = 1'b1;
          end
          default:    cbranch_s = 1'b0;
        endcase
      end
      6'h02: jump_s = 1'b1;
      6'h03: begin
        jump_s = 1'b1;
        wr_s   = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: cbranch_s = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: wr_s = 1'b1;
      6'h20, 6'h24: begin
        load_s = 1'b1;
        size_s = SZ_BYTE;
      end
      6'h21, 6'h25: begin
        load_s = 1'b1;
        size_s = SZ_HALF;
      end
      6'h23: load_s = 1'b1;
      6'h28: begin
        store_s = 1'b1;
        size_s  = SZ_BYTE;
      end
      6'h29: begin
        store_s = 1'b1;
        size_s  = SZ_HALF;
      end
      6'h2B: store_s = 1'b1;
      default: wr_s = 1'b0;
    endcase
  end

  // Little-endian lane enables and alignment check for the access size
  always_comb begin
    be_s  = 4'b1111;
    mis_s = 1'b0;
    case (size_s)
      SZ_BYTE: be_s = 4'b0001 << addr_lo;
      SZ_HALF: begin
        be_s  = addr_lo[1] ? 4'b1100 : 4'b0011;
        mis_s = addr_lo[0];
      end
      default: mis_s = (addr_lo != 2'b00);
    endcase
  end

  // Class values as they will be after this edge (latched while in EXECUTE)
  always_comb begin
    if (state_r == S_EXEC) begin
      ld_n_s  = load_s;
      st_n_s  = store_s;
      wr_n_s  = wr_s;
      mis_n_s = mis_s & (load_s | store_s);
      be_n_s  = be_s;
    end else begin
      ld_n_s  = ld_r;
      st_n_s  = st_r;
      wr_n_s  = wr_r;
      mis_n_s = mis_r;
      be_n_s  = be_r;
    end
  end

`ifdef MIPS_FSM_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic            stall_s;

  // A stall is a held bus strobe that the slave has not accepted yet
  always_comb begin
    stall_s      = waitrequest & ((state_r == S_FETCH) |
                   ((state_r == S_MEM) & (ld_r | st_r) & ~mis_r));
    wd_expired_s = stall_s & (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));
  end

  // Consecutive stall-cycle counter, cleared whenever the bus moves
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r <= '0;
    end else if (stall_s && !wd_expired_s) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end
`else
  assign wd_expired_s = 1'b0;
`endif

  // Next-state logic. Once the delay slot retires, a pending halt target
  // sends the core to HALTED instead of FETCH.
  always_comb begin
    done_s = (delay_slot_r & halt_pending_r) ? S_HALT : S_FETCH;
    nxt_s  = state_r;
    case (state_r)
      S_RESET: nxt_s = S_FETCH;
      S_FETCH: begin
        if (wd_expired_s)     nxt_s = S_FAULT;
        else if (waitrequest) nxt_s = S_FETCH;
        else                  nxt_s = S_DEC;
      end
      S_DEC:   nxt_s = S_EXEC;
      S_EXEC:  nxt_s = S_MEM;
      S_MEM: begin
        if (mis_r)                            nxt_s = S_FAULT;
        else if (wd_expired_s)                nxt_s = S_FAULT;
        else if ((ld_r | st_r) & waitrequest) nxt_s = S_MEM;
        else if (ld_r)                        nxt_s = S_WB;
        else                                  nxt_s = done_s;
      end
      S_WB:    nxt_s = done_s;
      S_HALT:  nxt_s = S_HALT;
      S_FAULT: nxt_s = S_FAULT;
      default: nxt_s = S_RESET;
    endcase
  end

  // A redirect is latched only by a control instruction outside a delay slot
  always_comb begin
    take_s = (state_r == S_MEM) & (nxt_s != S_MEM) & ~delay_slot_r &
             (jmp_r | (br_r & branch_taken));
  end

  // State, instruction class and redirect/halt bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r            <= S_RESET;
      ld_r               <= 1'b0;
      st_r               <= 1'b0;
      wr_r               <= 1'b0;
      jmp_r              <= 1'b0;
      br_r               <= 1'b0;
      mis_r              <= 1'b0;
      be_r               <= 4'b0000;
      redirect_pending_r <= 1'b0;
      halt_pending_r     <= 1'b0;
      delay_slot_r       <= 1'b0;
    end else begin
      state_r <= nxt_s;
      ld_r    <= ld_n_s;
      st_r    <= st_n_s;
      wr_r    <= wr_n_s;
      mis_r   <= mis_n_s;
      be_r    <= be_n_s;
      if (state_r == S_EXEC) begin
        jmp_r <= jump_s;
        br_r  <= cbranch_s;
      end else begin
        jmp_r <= jmp_r;
        br_r  <= br_r;
      end
      if (take_s) begin
        redirect_pending_r <= 1'b1;
        halt_pending_r     <= (jump_target == HALT_ADDR);
      end else if ((state_r == S_FETCH) && (nxt_s == S_DEC)) begin
        redirect_pending_r <= 1'b0;
        halt_pending_r     <= halt_pending_r;
      end else if (delay_slot_r && (nxt_s == S_FETCH || nxt_s == S_HALT)) begin
        redirect_pending_r <= redirect_pending_r;
        halt_pending_r     <= 1'b0;
      end else begin
        redirect_pending_r <= redirect_pending_r;
        halt_pending_r     <= halt_pending_r;
      end
      if ((nxt_s == S_DEC) || (nxt_s == S_EXEC) || (nxt_s == S_MEM) || (nxt_s == S_WB)) begin
        delay_slot_r <= (state_r == S_FETCH) ? redirect_pending_r : delay_slot_r;
      end else begin
        delay_slot_r <= 1'b0;
      end
    end
  end

  // Registered strobes and enables, decoded from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      fault      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      byteenable <= 4'b0000;
      ir_write   <= 1'b0;
      reg_write  <= 1'b0;
    end else begin
      active    <= (nxt_s == S_FETCH) | (nxt_s == S_DEC) | (nxt_s == S_EXEC) |
                   (nxt_s == S_MEM) | (nxt_s == S_WB);
      fault     <= (nxt_s == S_FAULT);
      mem_read  <= (nxt_s == S_FETCH) | ((nxt_s == S_MEM) & ld_n_s & ~mis_n_s);
      mem_write <= (nxt_s == S_MEM) & st_n_s & ~mis_n_s;
      if (nxt_s == S_FETCH) begin
        byteenable <= 4'b1111;
      end else if ((nxt_s == S_MEM) && (ld_n_s || st_n_s) && !mis_n_s) begin
        byteenable <= be_n_s;
      end else begin
        byteenable <= 4'b0000;
      end
      ir_write  <= (nxt_s == S_DEC);
      reg_write <= ((nxt_s == S_MEM) & wr_n_s) | (nxt_s == S_WB);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Self-checking bench for mips_multicycle_fsm. The bench runs whole
// instructions. For each one it computes the expected per-cycle trace from
// the instruction class and the bus wait counts, then compares the trace
// against the DUT outputs on every cycle.
module tb_mips_multicycle_fsm;

  localparam logic [31:0] HALT = 32'h0000_0000;
  localparam int K_NOP = 0, K_ALU = 1, K_LD = 2, K_ST = 3;
  localparam int K_J = 4, K_JL = 5, K_BR = 6, K_BRL = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, func_code;
  logic [4:0]  rt_code;
  logic        waitrequest;
  logic [1:0]  addr_lo;
  logic        branch_taken;
  logic [31:0] jump_target;
  logic [2:0]  state;
  logic        active, mem_read, mem_write, ir_write, pc_write, pc_redirect;
  logic        reg_write, delay_slot, fault;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;

  // Reference-model state: a redirect is owed, and its target is the halt address
  logic m_redir, m_halt;

  always #5 clk = ~clk;

  mips_multicycle_fsm #(.HALT_ADDR(HALT), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .rt_code(rt_code), .waitrequest(waitrequest), .addr_lo(addr_lo),
    .branch_taken(branch_taken), .jump_target(jump_target), .state(state),
    .active(active), .mem_read(mem_read), .mem_write(mem_write),
    .byteenable(byteenable), .ir_write(ir_write), .pc_write(pc_write),
    .pc_redirect(pc_redirect), .reg_write(reg_write), .delay_slot(delay_slot),
    .fault(fault)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Packed as {state, mr, mw, be, irw, pcw, pcr, rw, ds, act, flt}
  task automatic expect_outs(input string tag, input logic [2:0] st, input logic mr,
                             input logic mw, input logic [3:0] be, input logic irw,
                             input logic pcw, input logic pcr, input logic rw,
                             input logic ds, input logic act, input logic flt);
    check_val(tag,
      {16'h0, state, mem_read, mem_write, byteenable, ir_write, pc_write, pc_redirect,
       reg_write, delay_slot, active, fault},
      {16'h0, st, mr, mw, be, irw, pcw, pcr, rw, ds, act, flt});
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return K_J;
        if (fn == 6'h09) return K_JL;
        if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B})
          return K_ALU;
        return K_NOP;
      end
      6'h01: begin
        if (rt == 5'd0 || rt == 5'd1) return K_BR;
        if (rt == 5'd16 || rt == 5'd17) return K_BRL;
        return K_NOP;
      end
      6'h02: return K_J;
      6'h03: return K_JL;
      6'h04, 6'h05, 6'h06, 6'h07: return K_BR;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return K_LD;
      6'h28, 6'h29, 6'h2B: return K_ST;
      default: return (op >= 6'h08 && op <= 6'h0F) ? K_ALU : K_NOP;
    endcase
  endfunction

  // Access size in bytes for loads/stores
  function automatic int nbytes(input logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] lanes(input logic [5:0] op, input logic [1:0] al);
    logic [3:0] one;
    one = 4'b0001;
    case (nbytes(op))
      1: return one << al;
      2: return al[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] al);
    return (al % nbytes(op)) != 0;
  endfunction

  // Runs one instruction against the model. res: 0 retired, 1 halted, 2 faulted
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                           input logic [1:0] al, input logic tk, input logic [31:0] tgt,
                           input int fw, input int mw, output int res);
    int  k;
    logic slot, mem;
    k = kind(op, fn, rt);
    mem = (k == K_LD) || (k == K_ST);
    opcode = op; func_code = fn; rt_code = rt; addr_lo = al;
    branch_taken = tk; jump_target = tgt;
    res = 0;
    for (int i = 0; i <= fw; i++) begin
      waitrequest = (i < fw);
      #1 expect_outs("fetch", 3'd0, 1'b1, 1'b0, 4'hF, 1'b0, ~waitrequest,
                     ~waitrequest & m_redir, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    slot = m_redir;
    m_redir = 1'b0;
    waitrequest = 1'($urandom_range(0, 1));
    #1 expect_outs("decode", 3'd1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, slot, 1'b1, 1'b0);
    cyc();
    waitrequest = 1'($urandom_range(0, 1));
    #1 expect_outs("execute", 3'd2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, slot, 1'b1, 1'b0);
    cyc();
    if (mem && misaligned(op, al)) begin
      waitrequest = 1'b0;
      #1 expect_outs("mem_misalign", 3'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, slot, 1'b1, 1'b0);
      cyc();
      #1 expect_outs("fault", 3'd6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      res = 2;
      return;
    end
    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        waitrequest = (i < mw);
        #1 expect_outs("mem_access", 3'd3, k == K_LD, k == K_ST, lanes(op, al), 1'b0, 1'b0,
                       1'b0, 1'b0, slot, 1'b1, 1'b0);
        cyc();
      end
      if (k == K_LD) begin
        waitrequest = 1'b0;
        #1 expect_outs("write_back", 3'd4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, slot, 1'b1, 1'b0);
        cyc();
      end
    end else begin
      waitrequest = 1'b0;
      #1 expect_outs("mem_nonmem", 3'd3, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0,
                     k == K_ALU || k == K_JL || k == K_BRL, slot, 1'b1, 1'b0);
      cyc();
      if (!slot && (k == K_J || k == K_JL || ((k == K_BR || k == K_BRL) && tk))) begin
        m_redir = 1'b1;
        m_halt  = (tgt == HALT);
      end
    end
    if (slot && m_halt) begin
      for (int i = 0; i < 3; i++) begin
        waitrequest = 1'($urandom_range(0, 1));
        #1 expect_outs("halted", 3'd5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
      end
      res = 1;
    end
    if (slot) m_halt = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    waitrequest = 1'b0;
    m_redir = 1'b0;
    m_halt = 1'b0;
    #1 expect_outs("reset", 3'd7, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] ops [22];
    logic [5:0] fns [8];
    logic [4:0] rts [5];
    logic [5:0] op, fn;
    logic [1:0] al;
    int res;
    ops = '{6'h09, 6'h0D, 6'h0F, 6'h08, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
            6'h2B, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h00, 6'h3F, 6'h10};
    fns = '{6'h21, 6'h20, 6'h2A, 6'h00, 6'h08, 6'h09, 6'h3F, 6'h18};
    rts = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd5};
    opcode = 6'h0; func_code = 6'h0; rt_code = 5'd0; addr_lo = 2'd0;
    branch_taken = 1'b0; jump_target = 32'h0;
    @(negedge clk);
    do_reset();

    // ADDIU, LB with three wait states, taken BEQ followed by ADDU
    run_instr(6'h09, 6'h00, 5'd0, 2'd0, 1'b0, 32'h4, 0, 0, res);
    run_instr(6'h20, 6'h00, 5'd0, 2'd2, 1'b0, 32'h4, 0, 3, res);
    run_instr(6'h04, 6'h00, 5'd0, 2'd0, 1'b1, 32'h0000_0100, 0, 0, res);
    run_instr(6'h00, 6'h21, 5'd0, 2'd0, 1'b0, 32'h4, 1, 0, res);

    // Random aligned instruction mix
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 21)];
      fn = fns[$urandom_range(0, 7)];
      al = 2'($urandom_range(0, 3));
      if (kind(op, fn, 5'd0) == K_LD || kind(op, fn, 5'd0) == K_ST) begin
        if (nbytes(op) == 4) al = 2'd0;
        else if (nbytes(op) == 2) al[0] = 1'b0;
      end
      run_instr(op, fn, rts[$urandom_range(0, 4)], al, 1'($urandom_range(0, 1)),
                $urandom | 32'h1, $urandom_range(0, 3), $urandom_range(0, 3), res);
    end

    // JR to the halt address, delay slot ORI, then HALTED
    do_reset();
    run_instr(6'h00, 6'h08, 5'd0, 2'd0, 1'b0, HALT, 0, 0, res);
    run_instr(6'h0D, 6'h00, 5'd0, 2'd0, 1'b0, 32'h4, 0, 0, res);
    check_val("halt_reached", res, 1);

    // Misaligned SH traps
    do_reset();
    run_instr(6'h29, 6'h00, 5'd0, 2'd1, 1'b0, 32'h4, 0, 0, res);
    check_val("fault_reached", res, 2);
    cyc();
    #1 expect_outs("fault_sticky", 3'd6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Long FETCH stall
    do_reset();
    waitrequest = 1'b1;
`ifdef MIPS_FSM_WATCHDOG_EN
    for (int i = 0; i < 16; i++) begin
      #1 expect_outs("stall", 3'd0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
    #1 expect_outs("watchdog", 3'd6, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset();
    waitrequest = 1'b1;
    cyc();
`else
    for (int i = 0; i < 20; i++) begin
      #1 expect_outs("stall", 3'd0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc();
    end
`endif
    // reset_n dropped mid-stall
    #2 reset_n = 1'b0;
    #1 expect_outs("reset_mid_stall", 3'd7, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    waitrequest = 1'b0;
    #1 expect_outs("post_reset", 3'd0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
